// File: rtl/bch_31_pkg.sv
// bch_31_pkg: shared constants and types for the BCH(31,21) encoder/decoder chain.
//   BCH_N / BCH_K / BCH_NPAR : code length, message length, parity length
//   BCH_GEN                  : generator polynomial g(x), bit i <-> x^i
//   bch_state_t              : encoder framing state {MSG, PAR}
package bch_31_pkg;

  localparam int BCH_N    = 31;
  localparam int BCH_K    = 21;
  localparam int BCH_NPAR = 10;

  localparam logic [10:0] BCH_GEN = 11'h769;

  typedef enum logic {
    MSG = 1'b0,
    PAR = 1'b1
  } bch_state_t;

  // Feedback term of the division LFSR: g(x) without its leading x^10 term.
  function automatic logic [BCH_NPAR-1:0] bch_feedback(input logic fb);
    logic [BCH_NPAR-1:0] term;
    if (fb) begin
      term = BCH_GEN[BCH_NPAR-1:0];
    end else begin
      term = {BCH_NPAR{1'b0}};
    end
    return term;
  endfunction

endpackage

// File: rtl/bch_31_lfsr.sv
// bch_31_lfsr: 10-bit remainder register computing m(x)*x^10 mod g(x).
//   clk, rst  : clock, asynchronous active-high reset
//   shift_en  : advance the register one step
//   load_msg  : 1 = divide in din (message phase), 0 = plain shift out (parity phase)
//   din       : message bit, highest degree first
//   clear     : synchronous clear, takes priority over shift_en
//   msb       : remainder bit of highest degree (next parity bit to emit)
module bch_31_lfsr
  import bch_31_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic load_msg,
  input  logic din,
  input  logic clear,
  output logic msb
);

  logic [BCH_NPAR-1:0] r;

  // Remainder register: divide during the message, then shift parity out MSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= {BCH_NPAR{1'b0}};
    end else if (clear) begin
      r <= {BCH_NPAR{1'b0}};
    end else if (shift_en) begin
      if (load_msg) begin
        r <= {r[BCH_NPAR-2:0], 1'b0} ^ bch_feedback(din ^ r[BCH_NPAR-1]);
      end else begin
        r <= {r[BCH_NPAR-2:0], 1'b0};
      end
    end else begin
      r <= r;
    end
  end

  assign msb = r[BCH_NPAR-1];

endmodule

// File: rtl/bch_31_encoder.sv
// bch_31_encoder: bit-serial systematic BCH(31,21) encoder.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : message bit handshake, in_data = m20 first
//   out_valid/out_ready : codeword bit handshake, out_data = c30 first .. c0 last
//   out_sof / out_eof   : mark c30 / c0
// Optional (macro BCH31_PARALLEL_OUT_EN): cw[30:0] holds the last full codeword,
//   cw_valid pulses for one cycle after c0 is transferred.
module bch_31_encoder
  import bch_31_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_data,
  output logic        out_sof,
  output logic        out_eof
`ifdef BCH31_PARALLEL_OUT_EN
  ,
  output logic [30:0] cw,
  output logic        cw_valid
`endif
);

  localparam logic [4:0] MSG_LAST = 5'(BCH_K - 1);
  localparam logic [4:0] PAR_LAST = 5'(BCH_N - BCH_K - 1);

  bch_state_t state;
  logic [4:0] cnt;
  logic       slot_free;
  logic       msg_take;
  logic       par_take;
  logic       par_bit;

  // The output register can take a new bit when empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == MSG) && slot_free;
  assign msg_take  = in_valid && in_ready;
  assign par_take  = (state == PAR) && slot_free;

  bch_31_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (msg_take || par_take),
    .load_msg (state == MSG),
    .din      (in_data),
    .clear    (par_take && (cnt == PAR_LAST)),
    .msb      (par_bit)
  );

  // Framing FSM and output register; outputs hold while stalled by out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MSG;
      cnt       <= 5'd0;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      case (state)
        MSG: begin
          if (msg_take) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_sof   <= (cnt == 5'd0);
            out_eof   <= 1'b0;
            if (cnt == MSG_LAST) begin
              state <= PAR;
              cnt   <= 5'd0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end else if (slot_free) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
          end
        end
        PAR: begin
          if (slot_free) begin
            out_data  <= par_bit;
            out_valid <= 1'b1;
            out_sof   <= 1'b0;
            out_eof   <= (cnt == PAR_LAST);
            if (cnt == PAR_LAST) begin
              state <= MSG;
              cnt   <= 5'd0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        default: begin
          state     <= MSG;
          cnt       <= 5'd0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef BCH31_PARALLEL_OUT_EN
  logic [29:0] shadow;

  // Collect transferred bits; on the c0 transfer publish the whole codeword.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow   <= 30'd0;
      cw       <= 31'd0;
      cw_valid <= 1'b0;
    end else if (out_valid && out_ready) begin
      shadow <= {shadow[28:0], out_data};
      if (out_eof) begin
        cw       <= {shadow, out_data};
        cw_valid <= 1'b1;
      end else begin
        cw_valid <= 1'b0;
      end
    end else begin
      cw_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_bch_31_encoder.sv
// tb_bch_31_encoder: randomized self-checking bench for bch_31_encoder.
// The reference model computes each codeword by polynomial long division and
// keeps a queue of the bits (with sof/eof) the DUT must emit, in order.
module tb_bch_31_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_data;
  logic        out_sof;
  logic        out_eof;
`ifdef BCH31_PARALLEL_OUT_EN
  logic [30:0] cw;
  logic        cw_valid;
`endif

  bch_31_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eof   (out_eof)
`ifdef BCH31_PARALLEL_OUT_EN
    ,
    .cw        (cw),
    .cw_valid  (cw_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic d;
    logic sof;
    logic eof;
    logic par;
  } ob_t;

  int          total = 0;
  int          bad = 0;
  ob_t         q[$];
  int          par_cnt = 0;
  int          msg_cnt = 0;
  logic [20:0] msg = 21'd0;
  logic [29:0] cap = 30'd0;
  logic [30:0] last_cw = 31'd0;
  int          frames = 0;
  logic        last_acc = 1'b0;
  logic        cwv_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Remainder of a 31-bit polynomial divided by g(x).
  function automatic logic [9:0] poly_rem(input logic [30:0] p);
    logic [30:0] v;
    logic [30:0] g;
    v = p;
    g = 31'h769;
    for (int i = 30; i >= 10; i--) begin
      if (v[i]) v = v ^ (g << (i - 10));
    end
    return v[9:0];
  endfunction

  function automatic logic [30:0] model_cw(input logic [20:0] m);
    logic [30:0] s;
    s = {m, 10'b0};
    return s | {21'b0, poly_rem(s)};
  endfunction

  // One clock: drive inputs after the falling edge, then compare and advance the model.
  task automatic step(input logic iv, input logic id, input logic ordy);
    logic        sf;
    int          pu;
    ob_t         o;
    logic [30:0] m;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    last_acc = in_valid && in_ready;
`ifdef BCH31_PARALLEL_OUT_EN
    chk("cw_valid", {31'b0, cw_valid}, {31'b0, cwv_pend});
    if (cw_valid) chk("cw_parallel", {1'b0, cw}, {1'b0, last_cw});
`endif
    cwv_pend = 1'b0;
    sf = !out_valid || out_ready;
    pu = par_cnt - ((out_valid && q.size() > 0 && q[0].par) ? 1 : 0);
    chk("in_ready", {31'b0, in_ready}, {31'b0, sf && (pu == 0)});
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_bit", 32'd1, 32'd0);
      end else begin
        o = q[0];
        chk("out_data", {31'b0, out_data}, {31'b0, o.d});
        chk("out_sof", {31'b0, out_sof}, {31'b0, o.sof});
        chk("out_eof", {31'b0, out_eof}, {31'b0, o.eof});
        if (out_ready) begin
          void'(q.pop_front());
          if (o.par) par_cnt--;
          if (o.eof) begin
            last_cw = {cap, out_data};
            frames++;
            chk("cw_div_g", {22'b0, poly_rem(last_cw)}, 32'd0);
            cwv_pend = 1'b1;
          end
          cap = {cap[28:0], out_data};
        end
      end
    end
    if (last_acc) begin
      msg = {msg[19:0], in_data};
      q.push_back('{d: in_data, sof: (msg_cnt == 0), eof: 1'b0, par: 1'b0});
      msg_cnt++;
      if (msg_cnt == 21) begin
        m = model_cw(msg);
        for (int i = 9; i >= 0; i--) q.push_back('{d: m[i], sof: 1'b0, eof: (i == 0), par: 1'b1});
        par_cnt += 10;
        msg_cnt = 0;
      end
    end
  endtask

  task automatic send_frame(input logic [20:0] m, input bit rnd);
    int  idx;
    int  guard;
    logic iv;
    logic ordy;
    idx = 20;
    guard = 0;
    while (idx >= 0 && guard < 1000) begin
      iv   = rnd ? (($urandom % 4) != 0) : 1'b1;
      ordy = rnd ? (($urandom % 4) != 0) : 1'b1;
      step(iv, m[idx], ordy);
      if (last_acc) idx--;
      guard++;
    end
    if (idx >= 0) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      step(1'b0, 1'b0, 1'b1);
      guard++;
    end
    chk("drained", q.size(), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int busy;
    int rdy;
    int guard;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {31'b0, out_data}, 32'd0);
    chk("rst_out_sof", {31'b0, out_sof}, 32'd0);
    chk("rst_out_eof", {31'b0, out_eof}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;

    // Hand-computed values pinning the model itself.
    chk("model_m1", {1'b0, model_cw(21'h000001)}, 32'h00000769);
    chk("model_ones", {1'b0, model_cw(21'h1FFFFF)}, 32'h7FFFFFFF);
    chk("model_zero", {1'b0, model_cw(21'h000000)}, 32'h00000000);

    prev = frames;
    send_frame(21'h000000, 1'b0);
    drain();
    chk("cw_all_zero", {1'b0, last_cw}, 32'h00000000);
    chk("frames_zero", frames, prev + 1);

    send_frame(21'h000001, 1'b0);
    drain();
    chk("cw_m0_only", {1'b0, last_cw}, 32'h00000769);

    send_frame(21'h1FFFFF, 1'b0);
    drain();
    chk("cw_all_ones", {1'b0, last_cw}, 32'h7FFFFFFF);

    // Continuous flow: output fully busy, input ready 21 of 31 cycles.
    step(1'b1, 1'($urandom % 2), 1'b1);
    busy = 0;
    rdy = 0;
    for (int i = 0; i < 93; i++) begin
      step(1'b1, 1'($urandom % 2), 1'b1);
      if (out_valid) busy++;
      if (in_ready) rdy++;
    end
    chk("busy_cycles", busy, 32'd93);
    chk("ready_cycles", rdy, 32'd63);
    guard = 0;
    while (msg_cnt != 0 && guard < 100) begin
      step(1'b1, 1'($urandom % 2), 1'b1);
      guard++;
    end
    drain();

    // Random messages with random handshake toggling.
    prev = frames;
    for (int f = 0; f < 25; f++) send_frame(21'($urandom), 1'b1);
    drain();
    chk("frames_random", frames, prev + 25);

    // Reset while parity bits are being emitted.
    send_frame(21'($urandom), 1'b0);
    guard = 0;
    while (par_cnt > 6 && guard < 100) begin
      step(1'b0, 1'b0, 1'b1);
      guard++;
    end
    chk("reached_parity", par_cnt, 32'd6);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_out_sof", {31'b0, out_sof}, 32'd0);
    chk("mid_rst_out_eof", {31'b0, out_eof}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    q.delete();
    par_cnt = 0;
    msg_cnt = 0;
    cwv_pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send_frame(21'h000001, 1'b0);
    drain();
    chk("cw_after_reset", {1'b0, last_cw}, 32'h00000769);
    step(1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
